// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative shift-add multiplier / restoring divider owning HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             hiWrite,
   input  logic             loWrite,
   input  logic [WIDTH-1:0] writeData,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int               CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_count;
   logic               r_is_div;
   logic               r_neg_a;
   logic               r_neg_b;
   logic               r_div_zero;
   logic [WIDTH-1:0]   r_src_a;
   logic [WIDTH-1:0]   r_opb;
   logic [WIDTH-1:0]   r_acc_hi;
   logic [WIDTH-1:0]   r_acc_lo;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_signed_op;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_shift;
   logic [WIDTH:0]     w_trial;
   logic               w_ge;
   logic [WIDTH-1:0]   w_iter_hi;
   logic [WIDTH-1:0]   w_iter_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fin;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_fin_hi;
   logic [WIDTH-1:0]   w_fin_lo;

   // Operand conditioning at the accept edge: signed ops work on magnitudes.
   assign w_signed_op = ~op[0];
   assign w_neg_a     = w_signed_op & srcA[WIDTH-1];
   assign w_neg_b     = w_signed_op & srcB[WIDTH-1];
   assign w_mag_a     = w_neg_a ? -srcA : srcA;
   assign w_mag_b     = w_neg_b ? -srcB : srcB;

   // Multiply step: conditional add of the multiplicand, then shift right.
   assign w_sum = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_opb : {WIDTH{1'b0}})};

   // Divide step: a set top bit means the shifted remainder already exceeds
   // any WIDTH-bit divisor, so the truncated difference is the correct result.
   assign w_shift = {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
   assign w_trial = {1'b0, w_shift} - {1'b0, r_opb};
   assign w_ge    = r_acc_hi[WIDTH-1] | ~w_trial[WIDTH];

   always_comb begin
      w_iter_hi = w_sum[WIDTH:1];
      w_iter_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
      if (r_is_div) begin
         w_iter_hi = w_ge ? w_trial[WIDTH-1:0] : w_shift;
         w_iter_lo = {r_acc_lo[WIDTH-2:0], w_ge};
      end
   end

   assign w_prod     = {r_acc_hi, r_acc_lo};
   assign w_prod_fin = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
   assign w_quot     = (r_neg_a ^ r_neg_b) ? -r_acc_lo : r_acc_lo;
   assign w_rem      = r_neg_a ? -r_acc_hi : r_acc_hi;

   always_comb begin
      w_fin_hi = w_prod_fin[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod_fin[WIDTH-1:0];
      if (r_is_div) begin
         if (r_div_zero) begin
            w_fin_hi = r_src_a;
            w_fin_lo = {WIDTH{1'b1}};
         end else begin
            w_fin_hi = w_rem;
            w_fin_lo = w_quot;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next_state = S_CALC;
         S_CALC:   if (r_count == LAST_ITER) w_next_state = S_FINISH;
         S_FINISH: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count    <= '0;
         r_is_div   <= 1'b0;
         r_neg_a    <= 1'b0;
         r_neg_b    <= 1'b0;
         r_div_zero <= 1'b0;
         r_src_a    <= '0;
         r_opb      <= '0;
         r_acc_hi   <= '0;
         r_acc_lo   <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= (r_state == S_FINISH);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_count    <= '0;
                  r_is_div   <= op[1];
                  r_neg_a    <= w_neg_a;
                  r_neg_b    <= w_neg_b;
                  r_div_zero <= op[1] & (srcB == '0);
                  r_src_a    <= srcA;
                  r_opb      <= w_mag_b;
                  r_acc_hi   <= '0;
                  r_acc_lo   <= w_mag_a;
               end else begin
                  if (hiWrite) r_hi <= writeData;
                  if (loWrite) r_lo <= writeData;
               end
            end
            S_CALC: begin
               r_acc_hi <= w_iter_hi;
               r_acc_lo <= w_iter_lo;
               r_count  <= r_count + CNT_W'(1);
            end
            S_FINISH: begin
               r_hi <= w_fin_hi;
               r_lo <= w_fin_lo;
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// Testbench for muldiv_unit: randomized and directed ops, scoreboard checked
// against an arithmetic reference model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] srcA;
   logic [W-1:0] srcB;
   logic         hiWrite;
   logic         loWrite;
   logic [W-1:0] writeData;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int             checks    = 0;
   int             errors    = 0;
   int             done_seen = 0;
   int             seen_snap;
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] exp_val;
   logic [W-1:0]   cap_hi;
   logic [W-1:0]   cap_lo;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .srcA      (srcA),
      .srcB      (srcB),
      .hiWrite   (hiWrite),
      .loWrite   (loWrite),
      .writeData (writeData),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   // Reference model: returns {hi, lo} from plain integer arithmetic.
   function automatic logic [2*W-1:0] model(input logic [1:0] o,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint         sa;
      longint         sb;
      logic [63:0]    q;
      logic [63:0]    rm;
      logic [2*W-1:0] r;
      sa = $signed(a);
      sb = $signed(b);
      r  = '0;
      case (o)
         2'b00: r = sa * sb;
         2'b01: r = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) r = {a, {W{1'b1}}};
            else begin
               q  = sa / sb;
               rm = sa % sb;
               r  = {rm[W-1:0], q[W-1:0]};
            end
         end
         default: begin
            if (b == 0) r = {a, {W{1'b1}}};
            else        r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: actual hi=%h lo=%h required no result", hi, lo);
         end else begin
            exp_val = exp_q.pop_front();
            check("result", {hi, lo}, exp_val);
         end
      end
   end

   // Called at a negedge with the unit idle (or in its done cycle).
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      op    = o;
      srcA  = a;
      srcB  = b;
      start = 1'b1;
      exp_q.push_back(model(o, a, b));
      @(posedge clk);
      #1;
      start  = 1'b0;
      cap_hi = hi;
      cap_lo = lo;
      check("busy_after_accept", {63'b0, busy}, 64'd1);
      check("done_clear_after_accept", {63'b0, done}, 64'd0);
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         srcA = $urandom;
         srcB = $urandom;
         op   = 2'($urandom);
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      check("latency", 64'(lat), 64'(W + 1));
      @(negedge clk);
   endtask

   task automatic wait_done();
      int found;
      found = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            found = 1;
            break;
         end
      end
      check("done_timeout", 64'(found), 64'd1);
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      op        = 2'b00;
      srcA      = '0;
      srcB      = '0;
      hiWrite   = 1'b0;
      loWrite   = 1'b0;
      writeData = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {63'b0, busy}, 64'd0);
      check("reset_done", {63'b0, done}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);

      // Abort mid-calculation with reset.
      op    = 2'b01;
      srcA  = 32'h0001_2345;
      srcB  = 32'h0000_0777;
      start = 1'b1;
      exp_q.push_back(model(2'b01, 32'h0001_2345, 32'h0000_0777));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset     = 1'b1;
      seen_snap = done_seen;
      @(posedge clk);
      #1;
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_done", {63'b0, done}, 64'd0);
      check("abort_hilo", {hi, lo}, 64'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("no_done_after_abort", 64'(done_seen), 64'(seen_snap));

      // MTHI/MTLO in idle, then start beating a coincident MTLO.
      hiWrite   = 1'b1;
      loWrite   = 1'b1;
      writeData = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      hiWrite = 1'b0;
      loWrite = 1'b0;
      check("mthi_mtlo", {hi, lo}, 64'hDEADBEEF_DEADBEEF);
      @(negedge clk);
      loWrite   = 1'b1;
      writeData = 32'h12345678;
      run_op(2'b01, 32'd2, 32'd3);
      loWrite = 1'b0;
      check("start_beats_mtlo", {cap_hi, cap_lo}, 64'hDEADBEEF_DEADBEEF);

      run_op(2'b00, 32'hFFFFFFFD, 32'd5);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2);
      run_op(2'b11, 32'd100, 32'd0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);

      // Start and MTHI while busy must both be ignored.
      op    = 2'b01;
      srcA  = 32'd7;
      srcB  = 32'd6;
      start = 1'b1;
      exp_q.push_back(model(2'b01, 32'd7, 32'd6));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      start     = 1'b1;
      op        = 2'b10;
      srcA      = $urandom;
      srcB      = $urandom;
      hiWrite   = 1'b1;
      writeData = 32'hA5A5A5A5;
      @(negedge clk);
      start   = 1'b0;
      hiWrite = 1'b0;
      check("hilo_hold_in_calc", {hi, lo}, 64'h00000000_80000000);
      wait_done();
      run_op(2'b00, $urandom, $urandom);

      for (int n = 0; n < 40; n++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            2: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
            3: rb = -($urandom_range(1, 20));
            default: ;
         endcase
         run_op(ro, ra, rb);
      end

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
